inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the first write address after reset or start.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, pulse that restarts the write pointer and counters.
REQ-005 SHALL have port in_valid, input, 1, meaning a field set is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the field set is accepted this cycle.
REQ-007 SHALL have port in_fmt, input, 3, format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal.
REQ-008 SHALL have ports in_opcode (7), in_rd (5), in_rs1 (5), in_rs2 (5), in_funct3 (3) and in_funct7 (7), all inputs carrying raw instruction fields.
REQ-009 SHALL have port in_imm, input, 32, the signed immediate value in the same form an immediate generator outputs.
REQ-010 SHALL have port mem_we, output, 1, meaning a write is pending.
REQ-011 SHALL have port mem_ready, input, 1, meaning the memory accepts the pending write this cycle.
REQ-012 SHALL have port mem_addr, output, 32, the byte address of the pending write.
REQ-013 SHALL have port mem_wdata, output, 32, the encoded instruction.
REQ-014 SHALL have port wr_count, output, 16, the number of words accepted since reset or start.
REQ-015 SHALL have port err_count, output, 8, the number of rejected field sets, saturating at 255.

Function
REQ-016 SHALL hold one output register (mem_we/mem_addr/mem_wdata); in_ready = !mem_we || mem_ready, combinationally.
REQ-017 SHALL treat acceptance as in_valid && in_ready; a legal set loads the output register at the next edge (latency 1), with mem_addr = wr_ptr, then wr_ptr += 4 (wraps mod 2^32) and wr_count += 1 (wraps).
REQ-018 SHALL clear mem_we on the edge where mem_we && mem_ready and no new legal set is accepted; a simultaneous accept reloads the register without a bubble.
REQ-019 SHALL hold mem_addr and mem_wdata stable while mem_we && !mem_ready.
REQ-020 SHALL encode R as {funct7,rs2,rs1,funct3,rd,opcode} and I as {imm[11:0],rs1,funct3,rd,opcode}.
REQ-021 SHALL encode S as {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode} and B as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
REQ-022 SHALL encode U as {imm[31:12],rd,opcode} and J as {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-023 SHALL treat a set as legal under these rules: I and S need -2048..2047; B needs -4096..4094 and even; U needs imm[11:0]==0; J needs -1048576..1048574 and even; R ignores imm; fmt 6-7 is always illegal.
REQ-024 SHALL still accept an illegal set (in_ready unchanged), but SHALL write nothing, leave wr_ptr and wr_count unchanged, and increment err_count (saturating).
REQ-025 SHALL, on start, set wr_ptr = BASE_ADDR and clear wr_count and err_count; a pending output word keeps its address and data.
REQ-026 SHALL give start priority when it coincides with an accepted legal set: that word is written at BASE_ADDR, and afterwards wr_ptr = BASE_ADDR+4 and wr_count = 1.
REQ-027 SHALL pass every legal set through the round trip: an immediate generator applied to mem_wdata returns in_imm.

Reset
REQ-028 SHALL, while rst_n = 0, force mem_we=0, mem_addr=0, mem_wdata=0, wr_ptr=BASE_ADDR, wr_count=0 and err_count=0, independent of clk.
REQ-029 SHALL abandon any pending write when reset is asserted mid-transfer; after reset deasserts, in_ready=1 on the first cycle.

Structure
REQ-030 SHALL take the format codes, opcode constants (LOAD, OP-IMM, STORE, BRANCH, AUIPC, LUI, JALR, JAL) and immediate range limits from shared package rv32i_pkg.
REQ-031 SHALL place the field packing and legality check in one combinational sub-module, inst_pack; inst_encoder holds the handshake, pointer and counters.

Verification
REQ-032 SHALL cover: I, opcode 0010011, rd=2, rs1=2, f3=0, imm=-128 -> mem_wdata=f8010113, mem_addr=BASE_ADDR, one cycle later.
REQ-033 SHALL cover back-to-back S (0100011, rs2=1, rs1=2, f3=2, imm=124), then B (1100011, rs1=14, rs2=15, f3=1, imm=20), then B (rs1=15, rs2=14, f3=5, imm=-720) -> 06112e23, 00f71a63, d2e7d8e3 at addresses +0, +4 and +8.
REQ-034 SHALL cover J (1101111, rd=1, imm=16) -> 010000ef, and U (0110111, rd=2, imm=32'h08030000) -> 08030137.
REQ-035 SHALL cover illegal sets I imm=2048, B imm=21 and fmt=6 -> no mem_we, err_count=3, wr_ptr unchanged.
REQ-036 SHALL cover mem_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0 and mem_addr/mem_wdata stable; after release, the next word follows with no bubble.
REQ-037 SHALL cover start asserted together with an accepted legal set -> word written at BASE_ADDR, wr_count=1; rst_n asserted mid-stall -> mem_we=0 immediately.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: instruction format codes, major opcodes and the
// signed immediate ranges each format can represent.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM13_MIN = -4096;
  localparam int signed IMM13_MAX = 4094;
  localparam int signed IMM21_MIN = -1048576;
  localparam int signed IMM21_MAX = 1048574;

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer: scatters the immediate into the format's
// bit positions and flags sets whose immediate the format cannot represent.
module inst_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]         fmt_i,
  input  logic [6:0]         opcode_i,
  input  logic [4:0]         rd_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic [2:0]         funct3_i,
  input  logic [6:0]         funct7_i,
  input  logic signed [31:0] imm_i,
  output logic [31:0]        word_o,
  output logic               legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    case (fmt_i)
      FMT_R: begin
        word_o  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = 1'b1;
      end
      FMT_I: begin
        word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = (imm_i >= IMM12_MIN) && (imm_i <= IMM12_MAX);
      end
      FMT_S: begin
        word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal_o = (imm_i >= IMM12_MIN) && (imm_i <= IMM12_MAX);
      end
      FMT_B: begin
        word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        legal_o = (imm_i >= IMM13_MIN) && (imm_i <= IMM13_MAX) && !imm_i[0];
      end
      FMT_U: begin
        word_o  = {imm_i[31:12], rd_i, opcode_i};
        legal_o = (imm_i[11:0] == 12'd0);
      end
      FMT_J: begin
        word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        legal_o = (imm_i >= IMM21_MIN) && (imm_i <= IMM21_MAX) && !imm_i[0];
      end
      default: begin
        word_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts field sets, packs legal ones into one output
// word register with a valid/ready write port, and tracks write/error counts.
module inst_encoder
  import rv32i_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [15:0] wr_count,
  output logic [7:0]  err_count
);

  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ptr_q, ptr_d;
  logic [15:0] wrcnt_q, wrcnt_d;
  logic [7:0]  errcnt_q, errcnt_d;

  logic        accept;
  logic [31:0] pack_word;
  logic        pack_legal;
  logic [31:0] ptr_base;
  logic [15:0] wrcnt_base;
  logic [7:0]  errcnt_base;

  inst_pack u_pack (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .word_o   (pack_word),
    .legal_o  (pack_legal)
  );

  assign in_ready = !we_q || mem_ready;
  assign accept   = in_valid && in_ready;

  // start rebases pointer and counters before the current acceptance is applied
  assign ptr_base    = start ? BASE_ADDR : ptr_q;
  assign wrcnt_base  = start ? 16'd0 : wrcnt_q;
  assign errcnt_base = start ? 8'd0 : errcnt_q;

  always_comb begin
    we_d     = we_q && !mem_ready;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ptr_d    = ptr_base;
    wrcnt_d  = wrcnt_base;
    errcnt_d = errcnt_base;
    if (accept && pack_legal) begin
      we_d    = 1'b1;
      addr_d  = ptr_base;
      wdata_d = pack_word;
      ptr_d   = ptr_base + 32'd4;
      wrcnt_d = wrcnt_base + 16'd1;
    end else if (accept && (errcnt_base != 8'hFF)) begin
      errcnt_d = errcnt_base + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ptr_q    <= BASE_ADDR;
      wrcnt_q  <= '0;
      errcnt_q <= '0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ptr_q    <= ptr_d;
      wrcnt_q  <= wrcnt_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wr_count  = wrcnt_q;
  assign err_count = errcnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed encodings, handshake corner cases and a
// randomized run scored by decoding each written word back into its fields.
module tb_inst_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, mem_we, mem_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, mem_addr, mem_wdata;
  logic [15:0] wr_count;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  inst_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wr_count(wr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  // Reference legality: plain integer range arithmetic on the immediate
  function automatic bit legal_m(input logic [2:0] f, input logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (f)
      3'd0:    return 1'b1;
      3'd1,
      3'd2:    return (v >= -2048) && (v <= 2047);
      3'd3:    return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      3'd4:    return imm[11:0] == 12'd0;
      3'd5:    return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Immediate generator plus field extraction: the word must decode back to its inputs
  function automatic bit decodes_to(input exp_t e, input logic [31:0] w);
    logic [31:0] g;
    bit ok;
    ok = (w[6:0] == e.op);
    case (e.fmt)
      3'd1: g = {{20{w[31]}}, w[31:20]};
      3'd2: g = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3: g = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4: g = {w[31:12], 12'd0};
      3'd5: g = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: g = e.imm;
    endcase
    if (e.fmt != 3'd0 && g != e.imm) ok = 1'b0;
    if ((e.fmt == 3'd0 || e.fmt == 3'd1 || e.fmt == 3'd4 || e.fmt == 3'd5) && w[11:7] != e.rd) ok = 1'b0;
    if ((e.fmt <= 3'd3) && (w[19:15] != e.rs1 || w[14:12] != e.f3)) ok = 1'b0;
    if ((e.fmt == 3'd0 || e.fmt == 3'd2 || e.fmt == 3'd3) && w[24:20] != e.rs2) ok = 1'b0;
    if (e.fmt == 3'd0 && w[31:25] != e.f7) ok = 1'b0;
    return ok;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp += 6;
    if (mem_we !== 1'b0)     begin n_bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
    if (mem_addr !== 32'h0)  begin n_bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    if (wr_count !== 16'h0)  begin n_bad++; $display("FAIL rst_wrcnt: got %0d want 0", wr_count); end
    if (err_count !== 8'h0)  begin n_bad++; $display("FAIL rst_errcnt: got %0d want 0", err_count); end
    if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_i_word;
    drive(3'd1, 7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FF80);
    tick();
    in_valid = 1'b0;
    n_cmp += 4;
    if (mem_we !== 1'b1)           begin n_bad++; $display("FAIL i_we: got %b want 1", mem_we); end
    if (mem_wdata !== 32'hf8010113) begin n_bad++; $display("FAIL i_word: got %h want f8010113", mem_wdata); end
    if (mem_addr !== BASE)         begin n_bad++; $display("FAIL i_addr: got %h want %h", mem_addr, BASE); end
    if (wr_count !== 16'd1)        begin n_bad++; $display("FAIL i_wrcnt: got %0d want 1", wr_count); end
    tick();
    n_cmp++;
    if (mem_we !== 1'b0) begin n_bad++; $display("FAIL i_drain: got %b want 0", mem_we); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  fa[3]  = '{3'd2, 3'd3, 3'd3};
    logic [6:0]  oa[3]  = '{7'b0100011, 7'b1100011, 7'b1100011};
    logic [4:0]  r1a[3] = '{5'd2, 5'd14, 5'd15};
    logic [4:0]  r2a[3] = '{5'd1, 5'd15, 5'd14};
    logic [2:0]  f3a[3] = '{3'd2, 3'd1, 3'd5};
    logic [31:0] ia[3]  = '{32'd124, 32'd20, 32'hFFFF_FD30};
    logic [31:0] wa[3]  = '{32'h06112e23, 32'h00f71a63, 32'hd2e7d8e3};
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (wr_count !== 16'd0) begin n_bad++; $display("FAIL start_clr: got %0d want 0", wr_count); end
    for (int i = 0; i < 3; i++) begin
      drive(fa[i], oa[i], 5'd0, r1a[i], r2a[i], f3a[i], 7'd0, ia[i]);
      tick();
      n_cmp += 3;
      if (mem_we !== 1'b1) begin n_bad++; $display("FAIL b2b_we[%0d]: got %b want 1", i, mem_we); end
      if (mem_wdata !== wa[i]) begin n_bad++; $display("FAIL b2b_word[%0d]: got %h want %h", i, mem_wdata, wa[i]); end
      if (mem_addr !== BASE + 32'(4 * i)) begin
        n_bad++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, mem_addr, BASE + 32'(4 * i));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_j_u;
    drive(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
    tick();
    n_cmp += 2;
    if (mem_wdata !== 32'h010000ef) begin n_bad++; $display("FAIL j_word: got %h want 010000ef", mem_wdata); end
    if (mem_addr !== BASE + 32'd12) begin n_bad++; $display("FAIL j_addr: got %h want %h", mem_addr, BASE + 32'd12); end
    drive(3'd4, 7'b0110111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0803_0000);
    tick();
    in_valid = 1'b0;
    n_cmp += 2;
    if (mem_wdata !== 32'h08030137) begin n_bad++; $display("FAIL u_word: got %h want 08030137", mem_wdata); end
    if (mem_addr !== BASE + 32'd16) begin n_bad++; $display("FAIL u_addr: got %h want %h", mem_addr, BASE + 32'd16); end
    tick();
  endtask

  task automatic test_illegal;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048);
        1:       drive(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd21);
        default: drive(3'd6, 7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
      endcase
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      n_cmp++;
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL ill_we[%0d]: got %b want 0", i, mem_we); end
    end
    in_valid = 1'b0;
    n_cmp += 2;
    if (err_count !== 8'd3) begin n_bad++; $display("FAIL ill_err: got %0d want 3", err_count); end
    if (wr_count !== 16'd0) begin n_bad++; $display("FAIL ill_wrcnt: got %0d want 0", wr_count); end
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    n_cmp += 2;
    if (mem_addr !== BASE) begin n_bad++; $display("FAIL ill_ptr: got %h want %h", mem_addr, BASE); end
    if (mem_wdata !== 32'h00500093) begin n_bad++; $display("FAIL ill_next: got %h want 00500093", mem_wdata); end
    tick();
  endtask

  task automatic test_stall;
    mem_ready = 1'b0;
    drive(3'd0, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'hDEAD_BEEF);
    tick();
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      n_cmp += 4;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); end
      if (mem_we !== 1'b1) begin n_bad++; $display("FAIL stall_we[%0d]: got %b want 1", i, mem_we); end
      if (mem_addr !== BASE + 32'd4) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h want %h", i, mem_addr, BASE + 32'd4); end
      if (mem_wdata !== 32'h405201b3) begin n_bad++; $display("FAIL stall_word[%0d]: got %h want 405201b3", i, mem_wdata); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp += 3;
    if (mem_we !== 1'b1) begin n_bad++; $display("FAIL nobubble_we: got %b want 1", mem_we); end
    if (mem_addr !== BASE + 32'd8) begin n_bad++; $display("FAIL nobubble_addr: got %h want %h", mem_addr, BASE + 32'd8); end
    if (mem_wdata !== 32'h00100093) begin n_bad++; $display("FAIL nobubble_word: got %h want 00100093", mem_wdata); end
    tick();
    n_cmp++;
    if (mem_we !== 1'b0) begin n_bad++; $display("FAIL stall_drain: got %b want 0", mem_we); end
  endtask

  task automatic test_start_coincide;
    start = 1'b1;
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    start = 1'b0;
    drive(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
    n_cmp += 2;
    if (mem_addr !== BASE) begin n_bad++; $display("FAIL stcoin_addr: got %h want %h", mem_addr, BASE); end
    if (wr_count !== 16'd1) begin n_bad++; $display("FAIL stcoin_cnt: got %0d want 1", wr_count); end
    tick();
    in_valid = 1'b0;
    n_cmp += 2;
    if (mem_addr !== BASE + 32'd4) begin n_bad++; $display("FAIL stcoin_next: got %h want %h", mem_addr, BASE + 32'd4); end
    if (wr_count !== 16'd2) begin n_bad++; $display("FAIL stcoin_cnt2: got %0d want 2", wr_count); end
    tick();
  endtask

  task automatic test_err_saturate;
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (254) tick();
    n_cmp++;
    if (err_count !== 8'd254) begin n_bad++; $display("FAIL err_254: got %0d want 254", err_count); end
    repeat (6) tick();
    in_valid = 1'b0;
    n_cmp++;
    if (err_count !== 8'd255) begin n_bad++; $display("FAIL err_sat: got %0d want 255", err_count); end
    tick();
  endtask

  task automatic test_reset_midstall;
    mem_ready = 1'b0;
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got %b want 1", mem_we); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (mem_we !== 1'b0) begin n_bad++; $display("FAIL midrst_we: got %b want 0", mem_we); end
    if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_addr: got %h want 0", mem_addr); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp += 2;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL postrst_ready: got %b want 1", in_ready); end
    if (wr_count !== 16'd0) begin n_bad++; $display("FAIL postrst_cnt: got %0d want 0", wr_count); end
    mem_ready = 1'b1;
  endtask

  task automatic test_random;
    logic [31:0] exp_ptr;
    int exp_cnt, exp_err, r;
    logic [2:0] f;
    exp_t e, got;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_ptr = BASE; exp_cnt = 0; exp_err = 0;
    for (int c = 0; c < 404; c++) begin
      f = 3'($urandom_range(0, 7));
      r = int'($urandom_range(0, 3));
      e.fmt = f; e.op = 7'($urandom); e.rd = 5'($urandom); e.rs1 = 5'($urandom);
      e.rs2 = 5'($urandom); e.f3 = 3'($urandom); e.f7 = 7'($urandom);
      if (r == 0 || f == 3'd0 || f > 3'd5) e.imm = $urandom;
      else if (f == 3'd1 || f == 3'd2) e.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      else if (f == 3'd3) e.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      else if (f == 3'd4) e.imm = $urandom & 32'hFFFF_F000;
      else e.imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
      drive(e.fmt, e.op, e.rd, e.rs1, e.rs2, e.f3, e.f7, e.imm);
      in_valid  = (c < 400) && ($urandom_range(0, 3) != 0);
      mem_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== (!mem_we || mem_ready)) begin
        n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, !mem_we || mem_ready);
      end
      if (mem_we && mem_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL rnd_extra[%0d]: got write %h want none", c, mem_wdata);
        end else begin
          got = sb.pop_front();
          if (mem_addr !== got.addr || !decodes_to(got, mem_wdata)) begin
            n_bad++;
            $display("FAIL rnd_word[%0d]: got %h@%h want fmt%0d imm %h @%h", c, mem_wdata, mem_addr,
                     got.fmt, got.imm, got.addr);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (legal_m(e.fmt, e.imm)) begin
          e.addr = exp_ptr;
          sb.push_back(e);
          exp_ptr = exp_ptr + 32'd4;
          exp_cnt++;
        end else if (exp_err < 255) begin
          exp_err++;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp += 3;
    if (sb.size() != 0) begin n_bad++; $display("FAIL rnd_missing: got %0d left want 0", sb.size()); end
    if (wr_count !== 16'(exp_cnt)) begin n_bad++; $display("FAIL rnd_wrcnt: got %0d want %0d", wr_count, exp_cnt); end
    if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL rnd_errcnt: got %0d want %0d", err_count, exp_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
    test_reset();
    test_i_word();
    test_back_to_back();
    test_j_u();
    test_illegal();
    test_stall();
    test_start_coincide();
    test_err_saturate();
    test_reset_midstall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
